// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: two requesters, stall, and register-file write port.
// slave = arbiter side, master = requesters/register-file side.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              stall_in;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_sel;

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  stall_in,
        output wb_en, wb_rd, wb_data, wb_sel
    );

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output stall_in,
        input  wb_en, wb_rd, wb_data, wb_sel
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter of ALU (req0) and load (req1) write-backs into a
// single-entry output register feeding the register-file write port.
// Ports: clk, rst (async active-high), bus (wb_port_arbiter_if.slave).
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_port_arbiter_if.slave     bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;
    logic              sel_q;
    logic              last_q;
    logic              can_accept;
    logic              gnt0, gnt1, gnt;

    // Entry can be taken when empty, or when the held entry drains now.
    // Gated by rst so both readies stay low during reset.
    always_comb begin
        can_accept = !rst && ((state == EMPTY) || !bus.stall_in);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        gnt = gnt0 | gnt1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (gnt) state_nxt = FULL;
            FULL:  if (!bus.stall_in && !gnt) state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Payload and priority move only on a grant; idle cycles keep both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            data_q <= '0;
            sel_q  <= 1'b0;
            last_q <= 1'b1;
        end else if (gnt) begin
            rd_q   <= gnt1 ? bus.req1_rd   : bus.req0_rd;
            data_q <= gnt1 ? bus.req1_data : bus.req0_data;
            sel_q  <= gnt1;
            last_q <= gnt1;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    // x0 writes still occupy and drain the entry but never enable the write.
    assign bus.wb_en      = (state == FULL) && (rd_q != '0);
    assign bus.wb_rd      = rd_q;
    assign bus.wb_data    = data_q;
    assign bus.wb_sel     = sel_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: grants predicted by a small model,
// granted payloads queued and compared when they appear on the port.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        sel;
    } ent_t;

    ent_t        sbq[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic        m_full;
    logic        m_last;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_sel;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        m_rd   = '0;
        m_data = '0;
        m_sel  = 1'b0;
        sbq.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},   64'(bus.wb_en),   64'd0);
        check({tag, "_rd"},   64'(bus.wb_rd),   64'd0);
        check({tag, "_data"}, 64'(bus.wb_data), 64'd0);
        check({tag, "_sel"},  64'(bus.wb_sel),  64'd0);
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.stall_in   = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rdy0", 64'(bus.req0_ready), 64'd0);
        check("rst_rdy1", 64'(bus.req1_ready), 64'd0);
        check_zero("rst");
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: drive, predict grant, check ready, clock, check outputs.
    task automatic step(input logic v0, input logic [4:0] r0,
                        input logic [31:0] d0, input logic v1,
                        input logic [4:0] r1, input logic [31:0] d1,
                        input logic st);
        logic can, g0, g1;
        ent_t e;
        bus.req0_valid = v0;
        bus.req0_rd    = r0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_rd    = r1;
        bus.req1_data  = d1;
        bus.stall_in   = st;
        #1;
        can = !m_full || !st;
        g0  = can && v0 && (!v1 || m_last);
        g1  = can && v1 && (!v0 || !m_last);
        check("rdy0", 64'(bus.req0_ready), 64'(g0));
        check("rdy1", 64'(bus.req1_ready), 64'(g1));
        if (g0) sbq.push_back({r0, d0, 1'b0});
        if (g1) sbq.push_back({r1, d1, 1'b1});
        if (g0 || g1) begin
            m_full = 1'b1;
            m_last = g1;
        end else if (!st) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        if (g0 || g1) begin
            if (sbq.size() == 0) begin
                check("sbq_empty", 64'd0, 64'd1);
            end else begin
                e = sbq.pop_front();
                m_rd   = e.rd;
                m_data = e.data;
                m_sel  = e.sel;
            end
        end
        check("wb_en", 64'(bus.wb_en), 64'(m_full && (m_rd != 5'd0)));
        if (m_full) begin
            check("wb_rd",   64'(bus.wb_rd),   64'(m_rd));
            check("wb_data", 64'(bus.wb_data), 64'(m_data));
            check("wb_sel",  64'(bus.wb_sel),  64'(m_sel));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
        bus.stall_in   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // single ALU write-back, one-cycle latency
        step(1, 5'd3, 32'h0000_00AA, 0, 5'd0, 32'd0, 0);
        check("r33_en",   64'(bus.wb_en),   64'd1);
        check("r33_data", 64'(bus.wb_data), 64'hAA);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);

        // contested back-to-back: 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 5'(i + 1), 32'(100 + i), 1, 5'(i + 10), 32'(200 + i), 0);
            check("rr_sel", 64'(bus.wb_sel), 64'(i % 2));
        end
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);

        // hold under stall, then resume with round-robin
        do_reset();
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h1234_5678, 0);
        for (int i = 0; i < 3; i++)
            step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1);
        check("stall_rd", 64'(bus.wb_rd), 64'd7);
        step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0);
        check("resume_sel", 64'(bus.wb_sel), 64'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);

        // x0 write: occupies entry, never enables
        do_reset();
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        check("x0_en", 64'(bus.wb_en), 64'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
        step(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 1);

        // asynchronous reset while full and stalled
        do_reset();
        step(1, 5'd5, 32'h55AA, 0, 5'd0, 32'd0, 0);
        step(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        check("arst_rdy0", 64'(bus.req0_ready), 64'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 5'd9, 32'h99, 1, 5'd12, 32'hCC, 0);
        check("arst_first", 64'(bus.wb_sel), 64'd0);

        // single-requester cycles, stall while empty, then contest
        do_reset();
        step(0, 5'd0, 32'd0, 1, 5'd13, 32'hD0, 1);
        step(0, 5'd0, 32'd0, 1, 5'd14, 32'hE0, 0);
        step(1, 5'd15, 32'hF0, 1, 5'd16, 32'h100, 0);
        check("prio_sel", 64'(bus.wb_sel), 64'd0);

        // randomized traffic
        for (int i = 0; i < 60; i++)
            step(1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom_range(0, 2) == 0));

        if (sbq.size() != 0) check("sbq_left", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
